axi_std_master: RTL and testbench

- AXI4 full-protocol initiator that drives the Benes interconnect's AXI4 slave port from the bench/host side.
- Accepts one command at a time: either a write burst (local write stream → AW/W/B) or a read burst (AR/R → local read stream).
- Reports completion and response errors.
- Used in sim_resource benches and as the host-side shim in integration.

---
 rtl/axi_std_master.sv | 243 ++++++++++++++++++++++++
 tb/tb_axi_std_master.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_std_master.sv
// AXI4 full-protocol initiator: one write or read burst per command, local
// streams on each side, completion pulse with accumulated response error.
module axi_std_master #(
  parameter int C_M00_AXI_ID_WIDTH   = 1,
  parameter int C_M00_AXI_DATA_WIDTH = 512,
  parameter int C_M00_AXI_ADDR_WIDTH = 10
) (
  input  logic                              m00_axi_aclk,
  input  logic                              m00_axi_areset,
  input  logic                              cmd_valid,
  output logic                              cmd_ready,
  input  logic                              cmd_rnw,
  input  logic [C_M00_AXI_ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [7:0]                        cmd_len,
  input  logic                              wr_valid,
  output logic                              wr_ready,
  input  logic [C_M00_AXI_DATA_WIDTH-1:0]   wr_data,
  output logic                              rd_valid,
  input  logic                              rd_ready,
  output logic [C_M00_AXI_DATA_WIDTH-1:0]   rd_data,
  output logic                              rd_last,
  output logic                              done,
  output logic                              err,
  output logic [C_M00_AXI_ID_WIDTH-1:0]     m00_axi_awid,
  output logic [C_M00_AXI_ADDR_WIDTH-1:0]   m00_axi_awaddr,
  output logic [7:0]                        m00_axi_awlen,
  output logic [2:0]                        m00_axi_awsize,
  output logic [1:0]                        m00_axi_awburst,
  output logic                              m00_axi_awlock,
  output logic [3:0]                        m00_axi_awcache,
  output logic [2:0]                        m00_axi_awprot,
  output logic [3:0]                        m00_axi_awqos,
  output logic [3:0]                        m00_axi_awregion,
  output logic                              m00_axi_awuser,
  output logic                              m00_axi_awvalid,
  input  logic                              m00_axi_awready,
  output logic [C_M00_AXI_DATA_WIDTH-1:0]   m00_axi_wdata,
  output logic [C_M00_AXI_DATA_WIDTH/8-1:0] m00_axi_wstrb,
  output logic                              m00_axi_wlast,
  output logic                              m00_axi_wuser,
  output logic                              m00_axi_wvalid,
  input  logic                              m00_axi_wready,
  input  logic [C_M00_AXI_ID_WIDTH-1:0]     m00_axi_bid,
  input  logic [1:0]                        m00_axi_bresp,
  input  logic                              m00_axi_bvalid,
  output logic                              m00_axi_bready,
  output logic [C_M00_AXI_ID_WIDTH-1:0]     m00_axi_arid,
  output logic [C_M00_AXI_ADDR_WIDTH-1:0]   m00_axi_araddr,
  output logic [7:0]                        m00_axi_arlen,
  output logic [2:0]                        m00_axi_arsize,
  output logic [1:0]                        m00_axi_arburst,
  output logic                              m00_axi_arlock,
  output logic [3:0]                        m00_axi_arcache,
  output logic [2:0]                        m00_axi_arprot,
  output logic [3:0]                        m00_axi_arqos,
  output logic [3:0]                        m00_axi_arregion,
  output logic                              m00_axi_aruser,
  output logic                              m00_axi_arvalid,
  input  logic                              m00_axi_arready,
  input  logic [C_M00_AXI_ID_WIDTH-1:0]     m00_axi_rid,
  input  logic [C_M00_AXI_DATA_WIDTH-1:0]   m00_axi_rdata,
  input  logic [1:0]                        m00_axi_rresp,
  input  logic                              m00_axi_rlast,
  input  logic                              m00_axi_rvalid,
  output logic                              m00_axi_rready
);

  localparam int         STRB_W   = C_M00_AXI_DATA_WIDTH / 8;
  localparam logic [2:0] AXI_SIZE = 3'($clog2(STRB_W));

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WR_ADDR = 3'd1,
    S_WR_DATA = 3'd2,
    S_WR_RESP = 3'd3,
    S_RD_ADDR = 3'd4,
    S_RD_DATA = 3'd5,
    S_DONE    = 3'd6
  } state_t;

  state_t                            state_q;
  logic                              cmd_ready_q;
  logic                              awvalid_q;
  logic                              arvalid_q;
  logic                              bready_q;
  logic                              done_q;
  logic                              err_q;
  logic                              err_acc_q;
  logic [7:0]                        cnt_q;
  logic [7:0]                        len_q;
  logic [C_M00_AXI_ADDR_WIDTH-1:0]   addr_q;

  logic last_beat_s;
  logic in_wr_data_s;
  logic in_rd_data_s;
  logic w_hs_s;
  logic r_hs_s;
  logic rd_err_s;
  logic unused_ids_s;

  assign last_beat_s  = (cnt_q == len_q);
  assign in_wr_data_s = (state_q == S_WR_DATA);
  assign in_rd_data_s = (state_q == S_RD_DATA);
  assign w_hs_s       = in_wr_data_s && wr_valid && m00_axi_wready;
  assign r_hs_s       = in_rd_data_s && m00_axi_rvalid && rd_ready;
  // A read beat is bad if the slave flags it or its RLAST disagrees with our count.
  assign rd_err_s     = (m00_axi_rresp != 2'b00) || (m00_axi_rlast != last_beat_s);
  assign unused_ids_s = ^{m00_axi_bid, m00_axi_rid};

  // Command sequencing, beat counting and error accumulation.
  always_ff @(posedge m00_axi_aclk) begin
    if (m00_axi_areset) begin
      state_q     <= S_IDLE;
      cmd_ready_q <= 1'b0;
      awvalid_q   <= 1'b0;
      arvalid_q   <= 1'b0;
      bready_q    <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      err_acc_q   <= 1'b0;
      cnt_q       <= 8'd0;
      len_q       <= 8'd0;
      addr_q      <= '0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          cmd_ready_q <= 1'b1;
          if (cmd_valid && cmd_ready_q) begin
            cmd_ready_q <= 1'b0;
            addr_q      <= cmd_addr;
            len_q       <= cmd_len;
            awvalid_q   <= !cmd_rnw;
            arvalid_q   <= cmd_rnw;
            state_q     <= cmd_rnw ? S_RD_ADDR : S_WR_ADDR;
          end
        end
        S_WR_ADDR: begin
          if (m00_axi_awready) begin
            awvalid_q <= 1'b0;
            cnt_q     <= 8'd0;
            state_q   <= S_WR_DATA;
          end
        end
        S_WR_DATA: begin
          if (w_hs_s) begin
            cnt_q <= cnt_q + 8'd1;
            if (last_beat_s) begin
              bready_q <= 1'b1;
              state_q  <= S_WR_RESP;
            end
          end
        end
        S_WR_RESP: begin
          if (m00_axi_bvalid) begin
            bready_q  <= 1'b0;
            done_q    <= 1'b1;
            err_q     <= err_acc_q || (m00_axi_bresp != 2'b00);
            err_acc_q <= 1'b0;
            state_q   <= S_DONE;
          end
        end
        S_RD_ADDR: begin
          if (m00_axi_arready) begin
            arvalid_q <= 1'b0;
            cnt_q     <= 8'd0;
            state_q   <= S_RD_DATA;
          end
        end
        S_RD_DATA: begin
          if (r_hs_s) begin
            cnt_q <= cnt_q + 8'd1;
            if (last_beat_s) begin
              done_q    <= 1'b1;
              err_q     <= err_acc_q || rd_err_s;
              err_acc_q <= 1'b0;
              state_q   <= S_DONE;
            end else begin
              err_acc_q <= err_acc_q || rd_err_s;
            end
          end
        end
        S_DONE: begin
          cmd_ready_q <= 1'b1;
          state_q     <= S_IDLE;
        end
        default: begin
          cmd_ready_q <= 1'b0;
          awvalid_q   <= 1'b0;
          arvalid_q   <= 1'b0;
          bready_q    <= 1'b0;
          state_q     <= S_IDLE;
        end
      endcase
    end
  end

  assign cmd_ready        = cmd_ready_q;
  assign done             = done_q;
  assign err              = err_q;

  assign m00_axi_awid     = '0;
  assign m00_axi_awaddr   = addr_q;
  assign m00_axi_awlen    = len_q;
  assign m00_axi_awsize   = AXI_SIZE;
  assign m00_axi_awburst  = 2'b01;
  assign m00_axi_awlock   = 1'b0;
  assign m00_axi_awcache  = 4'd0;
  assign m00_axi_awprot   = 3'd0;
  assign m00_axi_awqos    = 4'd0;
  assign m00_axi_awregion = 4'd0;
  assign m00_axi_awuser   = 1'b0;
  assign m00_axi_awvalid  = awvalid_q;

  // W and R are straight pass-throughs, gated by the data phase of the burst.
  assign m00_axi_wdata    = wr_data;
  assign m00_axi_wstrb    = {STRB_W{1'b1}};
  assign m00_axi_wlast    = in_wr_data_s && last_beat_s;
  assign m00_axi_wuser    = 1'b0;
  assign m00_axi_wvalid   = in_wr_data_s && wr_valid;
  assign wr_ready         = in_wr_data_s && m00_axi_wready;
  assign m00_axi_bready   = bready_q;

  assign m00_axi_arid     = '0;
  assign m00_axi_araddr   = addr_q;
  assign m00_axi_arlen    = len_q;
  assign m00_axi_arsize   = AXI_SIZE;
  assign m00_axi_arburst  = 2'b01;
  assign m00_axi_arlock   = 1'b0;
  assign m00_axi_arcache  = 4'd0;
  assign m00_axi_arprot   = 3'd0;
  assign m00_axi_arqos    = 4'd0;
  assign m00_axi_arregion = 4'd0;
  assign m00_axi_aruser   = 1'b0;
  assign m00_axi_arvalid  = arvalid_q;

  assign rd_valid         = in_rd_data_s && m00_axi_rvalid;
  assign m00_axi_rready   = in_rd_data_s && rd_ready;
  assign rd_data          = m00_axi_rdata;
  assign rd_last          = in_rd_data_s && last_beat_s;

endmodule

// File: tb/tb_axi_std_master.sv
// Randomized bench for axi_std_master: acts as host and AXI slave, and checks
// every cycle against a transaction-level model of the burst protocol.
module tb_axi_std_master;

  localparam int DW = 512;
  localparam int AW = 10;
  localparam int IW = 1;
  localparam int SW = DW / 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          areset;
  logic          cmd_valid, cmd_ready, cmd_rnw;
  logic [AW-1:0] cmd_addr;
  logic [7:0]    cmd_len;
  logic          wr_valid, wr_ready;
  logic [DW-1:0] wr_data;
  logic          rd_valid, rd_ready, rd_last;
  logic [DW-1:0] rd_data;
  logic          done, err;
  logic [IW-1:0] awid, arid, bid, rid;
  logic [AW-1:0] awaddr, araddr;
  logic [7:0]    awlen, arlen;
  logic [2:0]    awsize, arsize, awprot, arprot;
  logic [1:0]    awburst, arburst, bresp, rresp;
  logic          awlock, arlock, awuser, aruser, wuser;
  logic [3:0]    awcache, arcache, awqos, arqos, awregion, arregion;
  logic          awvalid, awready, arvalid, arready;
  logic [DW-1:0] wdata, rdata;
  logic [SW-1:0] wstrb;
  logic          wlast, wvalid, wready, bvalid, bready;
  logic          rlast, rvalid, rready;

  axi_std_master #(
    .C_M00_AXI_ID_WIDTH(IW), .C_M00_AXI_DATA_WIDTH(DW), .C_M00_AXI_ADDR_WIDTH(AW)
  ) dut (
    .m00_axi_aclk(clk), .m00_axi_areset(areset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rnw(cmd_rnw),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last),
    .done(done), .err(err),
    .m00_axi_awid(awid), .m00_axi_awaddr(awaddr), .m00_axi_awlen(awlen),
    .m00_axi_awsize(awsize), .m00_axi_awburst(awburst), .m00_axi_awlock(awlock),
    .m00_axi_awcache(awcache), .m00_axi_awprot(awprot), .m00_axi_awqos(awqos),
    .m00_axi_awregion(awregion), .m00_axi_awuser(awuser),
    .m00_axi_awvalid(awvalid), .m00_axi_awready(awready),
    .m00_axi_wdata(wdata), .m00_axi_wstrb(wstrb), .m00_axi_wlast(wlast),
    .m00_axi_wuser(wuser), .m00_axi_wvalid(wvalid), .m00_axi_wready(wready),
    .m00_axi_bid(bid), .m00_axi_bresp(bresp), .m00_axi_bvalid(bvalid), .m00_axi_bready(bready),
    .m00_axi_arid(arid), .m00_axi_araddr(araddr), .m00_axi_arlen(arlen),
    .m00_axi_arsize(arsize), .m00_axi_arburst(arburst), .m00_axi_arlock(arlock),
    .m00_axi_arcache(arcache), .m00_axi_arprot(arprot), .m00_axi_arqos(arqos),
    .m00_axi_arregion(arregion), .m00_axi_aruser(aruser),
    .m00_axi_arvalid(arvalid), .m00_axi_arready(arready),
    .m00_axi_rid(rid), .m00_axi_rdata(rdata), .m00_axi_rresp(rresp),
    .m00_axi_rlast(rlast), .m00_axi_rvalid(rvalid), .m00_axi_rready(rready)
  );

  int checks   = 0;
  int failures = 0;
  logic [DW-1:0] wq [0:255];
  logic [DW-1:0] rq [0:255];

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] rnd_beat();
    logic [DW-1:0] r;
    for (int i = 0; i < DW / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic quiet_inputs();
    cmd_valid = 1'b0; cmd_rnw = 1'b0; cmd_addr = '0; cmd_len = 8'd0;
    wr_valid = 1'b0; wr_data = '0; rd_ready = 1'b0;
    awready = 1'b0; wready = 1'b0; arready = 1'b0;
    bid = '0; bresp = 2'b00; bvalid = 1'b0;
    rid = '0; rdata = '0; rresp = 2'b00; rlast = 1'b0; rvalid = 1'b0;
  endtask

  // Idle cycles with junk on the slave valids: nothing may be accepted or emitted.
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      cmd_valid = 1'b0;
      bvalid = 1'($urandom_range(0, 1)); rvalid = 1'($urandom_range(0, 1));
      rd_ready = 1'($urandom_range(0, 1)); wr_valid = 1'($urandom_range(0, 1));
      wready = 1'($urandom_range(0, 1)); awready = 1'($urandom_range(0, 1));
      #1;
      chk("idle_bready", bready, 1'b0);
      chk("idle_rready", rready, 1'b0);
      chk("idle_rd_valid", rd_valid, 1'b0);
      chk("idle_wvalid", wvalid, 1'b0);
      chk("idle_awvalid", awvalid, 1'b0);
      chk("idle_arvalid", arvalid, 1'b0);
      chk("idle_done", done, 1'b0);
    end
    @(negedge clk);
    quiet_inputs();
  endtask

  // One command end to end. The model tracks the burst purely by counting
  // handshakes it observes; expected outputs follow from those counts.
  task automatic run_cmd(input bit rnw, input logic [AW-1:0] addr, input logic [7:0] len,
                         input int stall, input int aw_delay, input bit w_alt,
                         input int err_beat, input logic [1:0] err_resp, input int bad_last,
                         input int abort_beat, input bit exp_ready_first,
                         output int lat, output logic got_err);
    bit accepted = 0, aw_done = 0, ar_done = 0, b_done = 0;
    bit done_due = 0, finished = 0, exp_err = 0, first = 1;
    bit exp_w, exp_r;
    int w_cnt = 0, r_cnt = 0, aw_wait = 0, cyc = 0, acc_cyc = 0;
    int n = int'(len);
    lat = -1; got_err = 1'bx;
    for (int i = 0; i <= n; i++) begin wq[i] = rnd_beat(); rq[i] = rnd_beat(); end
    while (!finished && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      cmd_valid = !accepted; cmd_rnw = rnw; cmd_addr = addr; cmd_len = len;
      wr_valid  = ($urandom_range(0, 99) >= stall);
      wr_data   = (w_cnt <= n) ? wq[w_cnt] : rnd_beat();
      awready   = (aw_wait >= aw_delay) && ($urandom_range(0, 99) >= stall);
      arready   = (aw_wait >= aw_delay) && ($urandom_range(0, 99) >= stall);
      wready    = w_alt ? 1'(cyc % 2) : 1'($urandom_range(0, 99) >= stall);
      bvalid    = !rnw && (w_cnt == n + 1) && !b_done && ($urandom_range(0, 99) >= stall);
      bresp     = (err_beat >= 0) ? err_resp : 2'b00;
      rvalid    = rnw && ar_done && (r_cnt <= n) && ($urandom_range(0, 99) >= stall);
      rdata     = (r_cnt <= n) ? rq[r_cnt] : rnd_beat();
      rresp     = (r_cnt == err_beat) ? err_resp : 2'b00;
      rlast     = (r_cnt == n) ^ (r_cnt == bad_last);
      rd_ready  = ($urandom_range(0, 99) >= stall);
      if (abort_beat >= 0 && !rnw && aw_done && w_cnt == abort_beat) begin
        areset = 1'b1;
        return;
      end
      #1;
      if (first && exp_ready_first) chk("cmd_ready_idle", cmd_ready, 1'b1);
      first = 0;
      if (accepted) chk("cmd_ready_busy", cmd_ready, 1'b0);
      chk("awvalid", awvalid, accepted && !rnw && !aw_done);
      if (accepted && !rnw && !aw_done) begin
        chk("awaddr", awaddr, addr); chk("awlen", awlen, len);
        chk("awburst", awburst, 2'b01); chk("awid", awid, 1'b0);
      end
      chk("arvalid", arvalid, accepted && rnw && !ar_done);
      if (accepted && rnw && !ar_done) begin
        chk("araddr", araddr, addr); chk("arlen", arlen, len);
        chk("arsize", arsize, 3'd6); chk("arburst", arburst, 2'b01);
      end
      exp_w = !rnw && aw_done && (w_cnt <= n);
      chk("wvalid", wvalid, exp_w && wr_valid);
      chk("wr_ready", wr_ready, exp_w && wready);
      if (exp_w && wr_valid) begin
        chk("wdata", wdata, wr_data);
        chk("wlast", wlast, w_cnt == n);
        chk("wstrb", wstrb, {SW{1'b1}});
      end
      chk("bready", bready, !rnw && (w_cnt == n + 1) && !b_done);
      exp_r = rnw && ar_done && (r_cnt <= n);
      chk("rd_valid", rd_valid, exp_r && rvalid);
      chk("rready", rready, exp_r && rd_ready);
      if (exp_r && rvalid) begin
        chk("rd_data", rd_data, rdata);
        chk("rd_last", rd_last, r_cnt == n);
      end
      chk("done", done, done_due);
      if (done_due) begin
        chk("err", err, exp_err);
        got_err = err; finished = 1; lat = cyc - acc_cyc;
      end
      done_due = 0;
      if (accepted && !aw_done && !ar_done) aw_wait++;
      if (!accepted && cmd_valid && cmd_ready) begin accepted = 1; acc_cyc = cyc; end
      if (awvalid && awready) aw_done = 1;
      if (arvalid && arready) ar_done = 1;
      if (wvalid && wready) begin
        if (w_cnt <= n) chk("w_order", wdata, wq[w_cnt]);
        w_cnt++;
      end
      if (bvalid && bready) begin
        b_done = 1; done_due = 1; exp_err = exp_err || (bresp != 2'b00);
      end
      if (rvalid && rready) begin
        if (r_cnt <= n) begin
          chk("rd_order", rd_data, rq[r_cnt]);
          if (rresp != 2'b00 || rlast != (r_cnt == n)) exp_err = 1;
          if (r_cnt == n) done_due = 1;
        end
        r_cnt++;
      end
    end
    if (!finished) begin
      checks++; failures++;
      $display("FAIL cmd_timeout actual=no_done required=done rnw=%0d len=%0d", rnw, len);
    end
  endtask

  int   lat;
  logic gerr;

  initial begin
    quiet_inputs();
    areset = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_cmd_ready", cmd_ready, 1'b0);
    chk("rst_awvalid", awvalid, 1'b0);
    chk("rst_arvalid", arvalid, 1'b0);
    chk("rst_bready", bready, 1'b0);
    chk("rst_rready", rready, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("tie_awsize", awsize, 3'd6);
    chk("tie_awcache", {awlock, awcache, awprot, awqos, awregion, awuser}, 17'd0);
    chk("tie_arcache", {arlock, arcache, arprot, arqos, arregion, aruser, wuser}, 18'd0);
    @(negedge clk); areset = 1'b0;
    idle(2);

    run_cmd(1'b0, 10'h040, 8'd3, 0, 0, 1'b0, -1, 2'b00, -1, -1, 1'b1, lat, gerr);
    chk("wr_len3_latency", 32'(lat), 32'd7);
    chk("wr_len3_err", gerr, 1'b0);
    run_cmd(1'b1, 10'h100, 8'd7, 40, 0, 1'b0, -1, 2'b00, -1, -1, 1'b1, lat, gerr);
    chk("rd_len7_err", gerr, 1'b0);
    run_cmd(1'b0, 10'h080, 8'd0, 0, 0, 1'b0, -1, 2'b00, -1, -1, 1'b1, lat, gerr);
    chk("wr_len0_latency", 32'(lat), 32'd4);
    run_cmd(1'b1, 10'h0c0, 8'd0, 0, 0, 1'b0, -1, 2'b00, -1, -1, 1'b1, lat, gerr);
    chk("rd_len0_latency", 32'(lat), 32'd3);
    run_cmd(1'b0, 10'h000, 8'd2, 20, 0, 1'b0, 0, 2'b10, -1, -1, 1'b1, lat, gerr);
    chk("wr_slverr", gerr, 1'b1);
    run_cmd(1'b1, 10'h200, 8'd3, 20, 0, 1'b0, 2, 2'b11, -1, -1, 1'b1, lat, gerr);
    chk("rd_decerr", gerr, 1'b1);
    run_cmd(1'b1, 10'h200, 8'd3, 20, 0, 1'b0, -1, 2'b00, -1, -1, 1'b1, lat, gerr);
    chk("err_cleared", gerr, 1'b0);
    run_cmd(1'b1, 10'h140, 8'd4, 10, 0, 1'b0, -1, 2'b00, 2, -1, 1'b1, lat, gerr);
    chk("rd_bad_rlast", gerr, 1'b1);
    run_cmd(1'b0, 10'h340, 8'd5, 0, 5, 1'b1, -1, 2'b00, -1, -1, 1'b1, lat, gerr);
    chk("aw_stall_err", gerr, 1'b0);
    run_cmd(1'b0, 10'h000, 8'd255, 20, 0, 1'b0, -1, 2'b00, -1, -1, 1'b1, lat, gerr);
    run_cmd(1'b1, 10'h000, 8'd255, 20, 0, 1'b0, -1, 2'b00, -1, -1, 1'b1, lat, gerr);

    // Reset partway through the write data phase.
    run_cmd(1'b0, 10'h1c0, 8'd5, 0, 0, 1'b0, -1, 2'b00, -1, 1, 1'b1, lat, gerr);
    @(negedge clk);
    wr_valid = 1'b1; wready = 1'b1; bvalid = 1'b1; rvalid = 1'b1; rd_ready = 1'b1;
    #1;
    chk("abort_wvalid", wvalid, 1'b0);
    chk("abort_awvalid", awvalid, 1'b0);
    chk("abort_bready", bready, 1'b0);
    chk("abort_rd_valid", rd_valid, 1'b0);
    chk("abort_cmd_ready", cmd_ready, 1'b0);
    chk("abort_done", done, 1'b0);
    areset = 1'b0;
    idle(2);
    #1;
    chk("post_reset_cmd_ready", cmd_ready, 1'b1);
    run_cmd(1'b1, 10'h240, 8'd1, 0, 0, 1'b0, -1, 2'b00, -1, -1, 1'b1, lat, gerr);
    chk("post_reset_read_err", gerr, 1'b0);

    for (int i = 0; i < 40; i++) begin
      bit         rnw = 1'($urandom_range(0, 1));
      logic [7:0] len = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(16, 63))
                                                     : 8'($urandom_range(0, 15));
      logic [AW-1:0] addr = {4'($urandom_range(0, 15)), 6'd0};
      int eb = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, int'(len))) : -1;
      int bl = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, int'(len))) : -1;
      run_cmd(rnw, addr, len, int'($urandom_range(0, 60)), int'($urandom_range(0, 3)),
              1'b0, eb, 2'($urandom_range(1, 3)), bl, -1, 1'b1, lat, gerr);
      if ($urandom_range(0, 2) == 0) idle(3);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
